// File: rtl/accel_spi_sequencer_pkg.sv
// Shared types and command constants for the accelerometer SPI sequencer.
package accel_pkg;

    typedef enum logic [2:0] {
        ST_BOOT,
        ST_SRST,
        ST_SRST_WAIT,
        ST_PWR,
        ST_IDLE,
        ST_READ
    } state_e;

    typedef enum logic {
        PH_ISSUE,
        PH_WAIT_DONE
    } phase_e;

    typedef enum logic [1:0] {
        TR_SRST,
        TR_PWR,
        TR_READ
    } txn_e;

    localparam logic [7:0] CMD_WRITE  = 8'h0A;
    localparam logic [7:0] CMD_READ   = 8'h0B;
    localparam logic [7:0] SOFT_RESET = 8'h1F;
    localparam logic [7:0] POWER_CTL  = 8'h2D;
    localparam logic [7:0] XDATA      = 8'h08;
    localparam logic [7:0] SRST_KEY   = 8'h52;
    localparam logic [7:0] MEAS_MODE  = 8'h02;

    localparam logic [2:0] LEN_SRST = 3'd3;
    localparam logic [2:0] LEN_PWR  = 3'd3;
    localparam logic [2:0] LEN_READ = 3'd5;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/accel_spi_sequencer_if.sv
// Request/response bundle between the sequencer and the SPI byte engine.
interface accel_spi_sequencer_if;
    logic       spi_start;
    logic [7:0] spi_tx_byte;
    logic       spi_keep_cs;
    logic       spi_busy;
    logic       spi_done;
    logic [7:0] spi_rx_byte;

    modport master (
        output spi_start, spi_tx_byte, spi_keep_cs,
        input  spi_busy, spi_done, spi_rx_byte
    );

    modport slave (
        input  spi_start, spi_tx_byte, spi_keep_cs,
        output spi_busy, spi_done, spi_rx_byte
    );
endinterface

// File: rtl/accel_spi_sequencer_rom.sv
// Combinational byte table: (transaction, byte index) -> (tx byte, keep_cs, last).
module accel_seq_rom
    import accel_pkg::*;
(
    input  txn_e       i_txn,
    input  logic [2:0] i_idx,
    output logic [7:0] o_tx_byte,
    output logic       o_keep_cs,
    output logic       o_last
);
    logic [2:0] w_len;

    always_comb begin
        w_len     = LEN_SRST;
        o_tx_byte = '0;
        case (i_txn)
            TR_SRST: begin
                w_len = LEN_SRST;
                case (i_idx)
                    3'd0:    o_tx_byte = CMD_WRITE;
                    3'd1:    o_tx_byte = SOFT_RESET;
                    3'd2:    o_tx_byte = SRST_KEY;
                    default: o_tx_byte = '0;
                endcase
            end
            TR_PWR: begin
                w_len = LEN_PWR;
                case (i_idx)
                    3'd0:    o_tx_byte = CMD_WRITE;
                    3'd1:    o_tx_byte = POWER_CTL;
                    3'd2:    o_tx_byte = MEAS_MODE;
                    default: o_tx_byte = '0;
                endcase
            end
            TR_READ: begin
                w_len = LEN_READ;
                case (i_idx)
                    3'd0:    o_tx_byte = CMD_READ;
                    3'd1:    o_tx_byte = XDATA;
                    default: o_tx_byte = '0;
                endcase
            end
            default: begin
                w_len     = LEN_SRST;
                o_tx_byte = '0;
            end
        endcase
        o_last    = (i_idx >= (w_len - 3'd1));
        o_keep_cs = ~o_last;
    end
endmodule

// File: rtl/accel_spi_sequencer.sv
// Boots the accelerometer (soft reset, measurement mode) and then reads
// X/Y/Z periodically through the SPI byte engine.
module accel_spi_sequencer
    import accel_pkg::*;
#(
    parameter int unsigned BOOT_WAIT     = 1000,
    parameter int unsigned CFG_WAIT      = 50000,
    parameter int unsigned SAMPLE_PERIOD = 100000,
    parameter int unsigned TIMEOUT       = 4096
) (
    input  logic                         clk,
    input  logic                         rst_n,
    accel_spi_sequencer_if.master        spi,
    input  logic                         enable,
    output logic [7:0]                   accel_x,
    output logic [7:0]                   accel_y,
    output logic [7:0]                   accel_z,
    output logic                         sample_valid,
    output logic                         cfg_done,
    output logic                         err
);
    localparam int unsigned CW =
        $clog2(max_u(max_u(BOOT_WAIT, CFG_WAIT), max_u(SAMPLE_PERIOD, TIMEOUT))) + 1;
    localparam logic [CW-1:0] BOOT_LAST    = CW'(BOOT_WAIT - 1);
    localparam logic [CW-1:0] CFG_LAST     = CW'(CFG_WAIT - 1);
    localparam logic [CW-1:0] PERIOD_LAST  = CW'(SAMPLE_PERIOD - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT - 1);

    state_e        r_state, w_state;
    phase_e        r_phase, w_phase;
    logic [2:0]    r_idx, w_idx;
    // One counter serves the wait states and the per-byte timeout; they never overlap.
    logic [CW-1:0] r_cnt, w_cnt;
    logic          r_start, w_start;
    logic [7:0]    r_tx, w_tx;
    logic          r_keep, w_keep;
    logic [7:0]    r_sx, w_sx, r_sy, w_sy;
    logic [7:0]    r_ax, w_ax, r_ay, w_ay, r_az, w_az;
    logic          r_valid, w_valid;
    logic          r_cfg, w_cfg;
    logic          r_err, w_err;

    txn_e          w_txn;
    logic [7:0]    w_rom_byte;
    logic          w_rom_keep;
    logic          w_rom_last;

    always_comb begin
        case (r_state)
            ST_PWR:  w_txn = TR_PWR;
            ST_READ: w_txn = TR_READ;
            default: w_txn = TR_SRST;
        endcase
    end

    accel_seq_rom u_rom (
        .i_txn     (w_txn),
        .i_idx     (r_idx),
        .o_tx_byte (w_rom_byte),
        .o_keep_cs (w_rom_keep),
        .o_last    (w_rom_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_BOOT;
            r_phase <= PH_ISSUE;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_start <= '0;
            r_tx    <= '0;
            r_keep  <= '0;
            r_sx    <= '0;
            r_sy    <= '0;
            r_ax    <= '0;
            r_ay    <= '0;
            r_az    <= '0;
            r_valid <= '0;
            r_cfg   <= '0;
            r_err   <= '0;
        end else begin
            r_state <= w_state;
            r_phase <= w_phase;
            r_idx   <= w_idx;
            r_cnt   <= w_cnt;
            r_start <= w_start;
            r_tx    <= w_tx;
            r_keep  <= w_keep;
            r_sx    <= w_sx;
            r_sy    <= w_sy;
            r_ax    <= w_ax;
            r_ay    <= w_ay;
            r_az    <= w_az;
            r_valid <= w_valid;
            r_cfg   <= w_cfg;
            r_err   <= w_err;
        end
    end

    always_comb begin
        w_state = r_state;
        w_phase = r_phase;
        w_idx   = r_idx;
        w_cnt   = r_cnt;
        w_start = '0;
        w_tx    = r_tx;
        w_keep  = r_keep;
        w_sx    = r_sx;
        w_sy    = r_sy;
        w_ax    = r_ax;
        w_ay    = r_ay;
        w_az    = r_az;
        w_valid = '0;
        w_cfg   = r_cfg;
        w_err   = r_err;
        case (r_state)
            ST_BOOT: begin
                if (r_cnt == BOOT_LAST) begin
                    w_state = ST_SRST;
                    w_phase = PH_ISSUE;
                    w_idx   = '0;
                    w_cnt   = '0;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            ST_SRST_WAIT: begin
                if (r_cnt == CFG_LAST) begin
                    w_state = ST_PWR;
                    w_phase = PH_ISSUE;
                    w_idx   = '0;
                    w_cnt   = '0;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            ST_IDLE: begin
                if (!enable) begin
                    w_cnt = '0;
                end else if (r_cnt == PERIOD_LAST) begin
                    w_state = ST_READ;
                    w_phase = PH_ISSUE;
                    w_idx   = '0;
                    w_cnt   = '0;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            default: begin
                if (r_phase == PH_ISSUE) begin
                    if (!spi.spi_busy) begin
                        w_start = '1;
                        w_tx    = w_rom_byte;
                        w_keep  = w_rom_keep;
                        w_phase = PH_WAIT_DONE;
                        w_cnt   = '0;
                    end
                end else if (spi.spi_done) begin
                    // done is checked before the timeout so a coincident done wins
                    w_cnt   = '0;
                    w_phase = PH_ISSUE;
                    if (r_state == ST_READ && r_idx == 3'd2) w_sx = spi.spi_rx_byte;
                    if (r_state == ST_READ && r_idx == 3'd3) w_sy = spi.spi_rx_byte;
                    if (w_rom_last) begin
                        w_idx = '0;
                        case (r_state)
                            ST_SRST: w_state = ST_SRST_WAIT;
                            ST_PWR: begin
                                w_state = ST_IDLE;
                                w_cfg   = '1;
                            end
                            default: begin
                                w_state = ST_IDLE;
                                w_ax    = r_sx;
                                w_ay    = r_sy;
                                w_az    = spi.spi_rx_byte;
                                w_valid = '1;
                            end
                        endcase
                    end else begin
                        w_idx = r_idx + 3'd1;
                    end
                end else if (r_cnt == TIMEOUT_LAST) begin
                    w_err   = '1;
                    w_cfg   = '0;
                    w_keep  = '0;
                    w_state = ST_BOOT;
                    w_phase = PH_ISSUE;
                    w_idx   = '0;
                    w_cnt   = '0;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
        endcase
    end

    assign spi.spi_start   = r_start;
    assign spi.spi_tx_byte = r_tx;
    assign spi.spi_keep_cs = r_keep;
    assign accel_x         = r_ax;
    assign accel_y         = r_ay;
    assign accel_z         = r_az;
    assign sample_valid    = r_valid;
    assign cfg_done        = r_cfg;
    assign err             = r_err;
endmodule

// File: tb/tb_accel_spi_sequencer.sv
// Randomized bench for accel_spi_sequencer with a behavioural SPI engine model.
module tb_accel_spi_sequencer;
    localparam int unsigned P_BOOT   = 4;
    localparam int unsigned P_CFG    = 8;
    localparam int unsigned P_PERIOD = 20;
    localparam int unsigned P_TO     = 16;
    localparam int          ENG_LAT  = 6;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] accel_x, accel_y, accel_z;
    logic       sample_valid, cfg_done, err;

    accel_spi_sequencer_if spi ();

    accel_spi_sequencer #(
        .BOOT_WAIT     (P_BOOT),
        .CFG_WAIT      (P_CFG),
        .SAMPLE_PERIOD (P_PERIOD),
        .TIMEOUT       (P_TO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .spi          (spi),
        .enable       (enable),
        .accel_x      (accel_x),
        .accel_y      (accel_y),
        .accel_z      (accel_z),
        .sample_valid (sample_valid),
        .cfg_done     (cfg_done),
        .err          (err)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Engine model state and a log of every byte the sequencer requested
    int          eng_cnt = 0;
    int          eng_pos = 0;
    bit          eng_read = 1'b0;
    logic [7:0]  eng_rx = '0;
    logic        m_busy = 1'b0;
    logic        force_busy = 1'b0;
    logic        withhold = 1'b0;
    logic [7:0]  rd_data [3];
    logic [7:0]  log_tx [$];
    logic        log_keep [$];
    int unsigned log_cyc [$];

    assign spi.spi_busy = m_busy | force_busy;

    initial begin
        spi.spi_done    = 1'b0;
        spi.spi_rx_byte = '0;
        forever begin
            @(posedge clk);
            #1;
            spi.spi_done = 1'b0;
            if (!rst_n) begin
                eng_cnt = 0;
            end else begin
                if (eng_cnt > 0) begin
                    eng_cnt--;
                    if (eng_cnt == 0) begin
                        spi.spi_done    = 1'b1;
                        spi.spi_rx_byte = eng_rx;
                    end
                end
                if (spi.spi_start) begin
                    if (spi.spi_tx_byte == 8'h0A || spi.spi_tx_byte == 8'h0B) begin
                        eng_pos  = 0;
                        eng_read = (spi.spi_tx_byte == 8'h0B);
                    end else begin
                        eng_pos++;
                    end
                    log_tx.push_back(spi.spi_tx_byte);
                    log_keep.push_back(spi.spi_keep_cs);
                    log_cyc.push_back(cyc);
                    eng_rx  = (eng_read && eng_pos >= 2) ? rd_data[eng_pos-2] : 8'(eng_pos);
                    eng_cnt = (eng_read && eng_pos == 3 && withhold) ? 0 : ENG_LAT;
                end
            end
            m_busy = (eng_cnt > 0);
        end
    end

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_sig(input string tag, input int which, input int unsigned limit,
                            output int unsigned at);
        bit hit = 1'b0;
        for (int unsigned i = 0; i < limit && !hit; i++) begin
            @(posedge clk);
            #2;
            case (which)
                0:       hit = sample_valid;
                1:       hit = cfg_done;
                2:       hit = err;
                default: hit = spi.spi_start;
            endcase
        end
        at = cyc;
        check_eq(tag, 32'(hit), 32'd1);
    endtask

    task automatic wait_log(input string tag, input int n, input int unsigned limit);
        bit hit = 1'b0;
        for (int unsigned i = 0; i < limit && !hit; i++) begin
            @(posedge clk);
            #2;
            hit = (log_tx.size() >= n);
        end
        check_eq(tag, 32'(hit), 32'd1);
    endtask

    // Expected byte lists and keep_cs pattern of each transaction kind
    task automatic check_txn(input string tag, input int base, input int kind);
        logic [7:0] exp [$];
        case (kind)
            0:       exp = '{8'h0A, 8'h1F, 8'h52};
            1:       exp = '{8'h0A, 8'h2D, 8'h02};
            default: exp = '{8'h0B, 8'h08, 8'h00, 8'h00, 8'h00};
        endcase
        check_eq({tag, "_len"}, 32'(log_tx.size() >= base + exp.size()), 32'd1);
        for (int i = 0; i < exp.size(); i++) begin
            check_eq($sformatf("%s_tx%0d", tag, i), 32'(log_tx[base+i]), 32'(exp[i]));
            check_eq($sformatf("%s_cs%0d", tag, i), 32'(log_keep[base+i]),
                     32'(i != exp.size() - 1));
        end
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, "_start"}, 32'(spi.spi_start), 32'd0);
        check_eq({tag, "_keep"}, 32'(spi.spi_keep_cs), 32'd0);
        check_eq({tag, "_tx"}, 32'(spi.spi_tx_byte), 32'd0);
        check_eq({tag, "_sv"}, 32'(sample_valid), 32'd0);
        check_eq({tag, "_cfg"}, 32'(cfg_done), 32'd0);
        check_eq({tag, "_err"}, 32'(err), 32'd0);
        check_eq({tag, "_ax"}, 32'(accel_x), 32'd0);
        check_eq({tag, "_ay"}, 32'(accel_y), 32'd0);
        check_eq({tag, "_az"}, 32'(accel_z), 32'd0);
    endtask

    task automatic new_sample();
        for (int i = 0; i < 3; i++) rd_data[i] = 8'($urandom_range(1, 255));
    endtask

    task automatic check_sample(input string tag);
        check_eq({tag, "_x"}, 32'(accel_x), 32'(rd_data[0]));
        check_eq({tag, "_y"}, 32'(accel_y), 32'(rd_data[1]));
        check_eq({tag, "_z"}, 32'(accel_z), 32'(rd_data[2]));
    endtask

    initial begin
        int unsigned t, v, idle_entry, b0, en;
        logic [7:0]  ox, oy, oz;
        bit          seen;

        new_sample();
        repeat (3) @(posedge clk);
        #2;
        check_reset("rst");

        // Bring-up with enable already high
        log_tx.delete(); log_keep.delete(); log_cyc.delete();
        enable = 1'b1;
        rst_n  = 1'b1;
        wait_sig("wait_cfg", 1, 400, t);
        check_txn("cfg_srst", 0, 0);
        check_txn("cfg_pwr", 3, 1);
        // wait cycles, plus the cycle after done and the ISSUE cycle
        check_eq("cfg_gap", log_cyc[3] - (log_cyc[2] + ENG_LAT), P_CFG + 2);
        check_eq("cfg_rise", t - (log_cyc[5] + ENG_LAT), 1);
        check_eq("cfg_err", 32'(err), 32'd0);

        idle_entry = t;
        for (int k = 0; k < 3; k++) begin
            new_sample();
            log_tx.delete(); log_keep.delete(); log_cyc.delete();
            wait_sig($sformatf("wait_sv%0d", k), 0, 200, v);
            check_txn($sformatf("rd%0d", k), 0, 2);
            check_sample($sformatf("rd%0d", k));
            check_eq($sformatf("rd%0d_period", k), log_cyc[0] - idle_entry, P_PERIOD + 1);
            check_eq($sformatf("rd%0d_svlat", k), v - (log_cyc[4] + ENG_LAT), 1);
            @(posedge clk);
            #2;
            check_eq($sformatf("rd%0d_svpulse", k), 32'(sample_valid), 32'd0);
            idle_entry = v;
        end

        // Engine busy across the READ ISSUE cycle
        new_sample();
        log_tx.delete(); log_keep.delete(); log_cyc.delete();
        repeat (14) @(posedge clk);
        #2;
        b0 = cyc;
        check_eq("busy_align", b0 - idle_entry, 15);
        force_busy = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #2;
            seen |= spi.spi_start;
        end
        force_busy = 1'b0;
        check_eq("busy_nostart", 32'(seen), 32'd0);
        @(posedge clk);
        #2;
        check_eq("busy_start", 32'(spi.spi_start), 32'd1);
        check_eq("busy_tx", 32'(spi.spi_tx_byte), 32'h0B);
        wait_sig("wait_sv_busy", 0, 200, v);
        check_sample("busy_rd");

        // Read byte 4 never completes
        ox = accel_x; oy = accel_y; oz = accel_z;
        new_sample();
        withhold = 1'b1;
        log_tx.delete(); log_keep.delete(); log_cyc.delete();
        wait_sig("wait_err", 2, 200, t);
        check_eq("to_lat", t - log_cyc[3], P_TO);
        check_eq("to_keep", 32'(spi.spi_keep_cs), 32'd0);
        check_eq("to_cfg", 32'(cfg_done), 32'd0);
        check_eq("to_x", 32'(accel_x), 32'(ox));
        check_eq("to_y", 32'(accel_y), 32'(oy));
        check_eq("to_z", 32'(accel_z), 32'(oz));
        withhold = 1'b0;
        log_tx.delete(); log_keep.delete(); log_cyc.delete();
        wait_sig("wait_recfg", 1, 400, t);
        check_txn("recfg_srst", 0, 0);
        check_txn("recfg_pwr", 3, 1);
        check_eq("to_sticky", 32'(err), 32'd1);

        // enable falls during read byte 2
        new_sample();
        log_tx.delete(); log_keep.delete(); log_cyc.delete();
        wait_log("wait_byte2", 2, 200);
        enable = 1'b0;
        wait_sig("wait_sv_dis", 0, 200, v);
        check_sample("dis_rd");
        log_tx.delete(); log_keep.delete(); log_cyc.delete();
        repeat (60) @(posedge clk);
        #2;
        check_eq("dis_quiet", log_tx.size(), 0);
        new_sample();
        enable = 1'b1;
        en = cyc;
        wait_sig("wait_reen", 3, 100, t);
        check_eq("reen_lat", t - en, P_PERIOD + 1);

        // Asynchronous reset while the read is in flight
        wait_log("wait_byte3", 3, 100);
        check_eq("mid_start_pre", 32'(spi.spi_start), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset("midrst");
        repeat (2) @(posedge clk);
        #2;
        log_tx.delete(); log_keep.delete(); log_cyc.delete();
        rst_n = 1'b1;
        wait_sig("wait_cfg2", 1, 400, t);
        check_txn("rst_srst", 0, 0);
        check_txn("rst_pwr", 3, 1);
        check_eq("rst_err", 32'(err), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/accel_spi_sequencer.md
# accel_spi_sequencer

Sequences the board accelerometer (ADXL362-style command set) through a byte-level SPI master engine. After reset it issues a soft reset, waits, and enables measurement mode. It then reads the X/Y/Z 8-bit data registers periodically and publishes them with a one-cycle valid strobe. It sits between the SPI byte engine and the sample FIFO/display logic, and is the only block that drives the engine's request side.

## Interface
Parameters:
- BOOT_WAIT, 1000: clk cycles after reset release before the first transaction.
- CFG_WAIT, 50000: clk cycles between soft-reset write completion and the power-control write.
- SAMPLE_PERIOD, 100000: clk cycles spent in IDLE between read transactions (must be ≥ 2).
- TIMEOUT, 4096: maximum clk cycles from spi_start to spi_done before error.

Ports:
- Clock and reset: one clock, `clk`; reset is asynchronous and active-low, `rst_n`.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  permits periodic reads; configuration runs regardless.
- spi_busy  in  1  engine is mid-byte; `spi_start` is illegal while high.
- spi_done  in  1  one-cycle pulse; the byte has finished and `spi_rx_byte` is valid.
- spi_rx_byte  in  8  byte shifted in from MISO.
- spi_start  out  1  one-cycle request to shift `spi_tx_byte`.
- spi_tx_byte  out  8  byte to send; held stable from `spi_start` through `spi_done`.
- spi_keep_cs  out  1  engine keeps CS low after this byte; held with `spi_tx_byte`.
- accel_x, accel_y, accel_z  out  8  last published sample.
- sample_valid  out  1  one-cycle pulse; all three axes are updated together.
- cfg_done  out  1  level; measurement mode is enabled.
- err  out  1  sticky timeout flag; cleared only by reset.

## Operation
- Transactions are byte lists. `spi_keep_cs` is 1 on every byte except the last.
  - Soft reset: 0x0A, 0x1F, 0x52.
  - Power control: 0x0A, 0x2D, 0x02.
  - Read: 0x0B, 0x08, 0x00, 0x00, 0x00. The `spi_rx_byte` values of bytes 3, 4 and 5 are X, Y and Z.
- States: BOOT → SRST → SRST_WAIT → PWR → IDLE ⇄ READ. A TIMEOUT in any transaction sends the block to BOOT.
  - BOOT counts BOOT_WAIT cycles, then enters SRST.
  - SRST, PWR and READ share a per-byte sub-sequence: ISSUE, then WAIT_DONE, with a 3-bit byte index.
  - SRST_WAIT counts CFG_WAIT cycles.
  - PWR completes, then `cfg_done` is set and the block enters IDLE.
  - IDLE counts SAMPLE_PERIOD cycles while `enable` = 1, then enters READ. The counter clears while `enable` = 0.
  - READ: X, Y and Z are captured into shadow registers. On the final `spi_done`, the shadows are copied to the outputs, `sample_valid` pulses and the block returns to IDLE.
- ISSUE asserts `spi_start` only when `spi_busy` = 0. Otherwise it waits in ISSUE.
- Timeout: the counter starts at `spi_start` and clears on `spi_done`. Reaching TIMEOUT does the following:
  - sets `err` and clears `cfg_done`;
  - drops `spi_keep_cs`;
  - returns to BOOT and re-runs the full configuration.
- Outputs are not updated by an aborted read.
- If `enable` falls mid-READ, the transaction completes and publishes; the block then holds in IDLE.
- `spi_done` outside WAIT_DONE is ignored.
- If `spi_done` and the timeout occur in the same cycle, `spi_done` wins.

## Timing
- Reset values: `spi_start`, `spi_keep_cs`, `sample_valid`, `cfg_done` and `err` = 0; `spi_tx_byte` and `accel_x/y/z` = 0x00; state BOOT.
- An asynchronous reset mid-transaction drops `spi_keep_cs` and `spi_start` immediately.
- All outputs are registered.
- `spi_start` rises one cycle after entering ISSUE with `spi_busy` low.
- The next byte's ISSUE occurs the cycle after `spi_done`.
- `sample_valid` and the new `accel_*` values appear one cycle after the Z-byte `spi_done`.
- `cfg_done` rises one cycle after the last PWR `spi_done`.
- The first READ `spi_start` occurs SAMPLE_PERIOD+1 cycles after IDLE entry with `enable` held high.
- All counters saturate or clear explicitly and never wrap. Counter widths are `$clog2` of the largest parameter plus 1.

## Structure
- Shared package `accel_pkg`:
  - state enum;
  - command constants CMD_WRITE = 0x0A and CMD_READ = 0x0B;
  - register addresses SOFT_RESET = 0x1F, POWER_CTL = 0x2D and XDATA = 0x08;
  - constants SRST_KEY = 0x52 and MEAS_MODE = 0x02;
  - per-transaction lengths.
- One sub-module, `accel_seq_rom`, which is combinational. It maps (transaction id, byte index) to (tx byte, keep_cs, last flag).

## Test plan
The bench uses BOOT_WAIT=4, CFG_WAIT=8, SAMPLE_PERIOD=20, TIMEOUT=16, plus a behavioural engine model that returns `spi_done` 6 cycles after `spi_start`.
- Reset release, engine model echoing byte index as rx → bytes 0A 1F 52, 8 idle cycles, then 0A 2D 02 are observed. `keep_cs` pattern is 1,1,0 for each transaction. `cfg_done` rises after the final 02.
- `enable` = 1, model returns 0x12, 0x34, 0x56 on bytes 3–5 → `accel_x/y/z` = 12/34/56 with a single `sample_valid` pulse. The next `spi_start` comes 21 cycles after IDLE entry.
- `spi_busy` held high for 10 cycles at an ISSUE → no `spi_start` while busy; the start fires the cycle after busy falls.
- Model withholds `spi_done` on read byte 4 → `err` rises 16 cycles after that start and `keep_cs` drops. `accel_*` keep their old values. The configuration sequence re-runs from BOOT.
- `enable` dropped during read byte 2 → the read completes and publishes, and no further `spi_start` occurs. After re-enable, the next read starts 21 cycles later.
- `rst_n` asserted mid-READ → all outputs return to reset values immediately. After release, the full configuration re-runs.
